mips_muldiv_unit: RTL and testbench

//  Parametrised iterative multiply/divide unit with HI/LO result registers.

---
 rtl/mips_muldiv_unit_if.sv | 26 ++
 rtl/mips_muldiv_unit.sv | 121 ++++++++++++
 tb/tb_mips_muldiv_unit.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_muldiv_unit_if.sv
// Pipeline-side bundle for the iterative multiply/divide unit.
// The master drives requests and mthi/mtlo writes; the slave returns status and HI/LO.
interface mips_muldiv_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, src_a, src_b, flush, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, flush, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mips_muldiv_unit.sv
// Iterative radix-2 MIPS mult/multu/div/divu unit with HI/LO registers.
// Operands are reduced to magnitudes on accept; signs are reapplied in FIN.
module mips_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  mips_muldiv_unit_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

  state_t             r_state, w_next;
  logic [CW-1:0]      r_cnt;
  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_a, r_b;
  logic               r_neg_q, r_neg_r;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_done;

  logic               w_accept, w_last, w_wr_ok;
  logic               w_sa, w_sb;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b;
  logic [WIDTH:0]     w_madd;
  logic [2*WIDTH-1:0] w_mstep, w_dstep, w_prod;
  logic [WIDTH:0]     w_rsh, w_sub;
  logic               w_qbit;
  logic [WIDTH-1:0]   w_quo, w_rem;

  assign w_accept = (r_state == S_IDLE) && bus.start && !bus.flush;
  assign w_wr_ok  = (r_state == S_IDLE) && !w_accept;
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  // op[0]=1 selects the unsigned variants
  assign w_sa    = ~bus.op[0] & bus.src_a[WIDTH-1];
  assign w_sb    = ~bus.op[0] & bus.src_b[WIDTH-1];
  assign w_abs_a = w_sa ? -bus.src_a : bus.src_a;
  assign w_abs_b = w_sb ? -bus.src_b : bus.src_b;

  // Shift-add: acc = {partial product, remaining multiplier bits}
  assign w_madd  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
  assign w_mstep = {w_madd, r_acc[WIDTH-1:1]};

  // Restoring divide: acc = {remainder, dividend/quotient}. A set top bit of
  // the shifted remainder means it already exceeds any WIDTH-bit divisor.
  assign w_rsh   = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_sub   = {1'b0, w_rsh[WIDTH-1:0]} - {1'b0, r_b};
  assign w_qbit  = w_rsh[WIDTH] | ~w_sub[WIDTH];
  assign w_dstep = {(w_qbit ? w_sub[WIDTH-1:0] : w_rsh[WIDTH-1:0]),
                    r_acc[WIDTH-2:0], w_qbit};

  // Sign fix. Divide-by-zero leaves remainder = |a|, which the dividend-sign
  // fix turns back into a; overflow (MIN/-1) falls out of the magnitude path.
  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_quo  = (r_b == '0) ? '1 :
                  (r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
  assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (bus.flush) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (bus.start) w_next = S_CALC;
        S_CALC:  if (w_last)    w_next = S_FIN;
        S_FIN:   w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_acc   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_op    <= bus.op;
        r_a     <= w_abs_a;
        r_b     <= w_abs_b;
        r_neg_q <= w_sa ^ w_sb;
        r_neg_r <= w_sa;
        r_cnt   <= '0;
        r_acc   <= bus.op[1] ? {{WIDTH{1'b0}}, w_abs_a} : {{WIDTH{1'b0}}, w_abs_b};
      end
      if (w_wr_ok && bus.hi_we) r_hi <= bus.wdata;
      if (w_wr_ok && bus.lo_we) r_lo <= bus.wdata;
      if (r_state == S_CALC && !bus.flush) begin
        r_acc <= r_op[1] ? w_dstep : w_mstep;
        r_cnt <= r_cnt + CW'(1);
      end
      if (r_state == S_FIN && !bus.flush) begin
        r_hi   <= r_op[1] ? w_rem : w_prod[2*WIDTH-1:WIDTH];
        r_lo   <= r_op[1] ? w_quo : w_prod[WIDTH-1:0];
        r_done <= 1'b1;
      end
    end
  end

  assign bus.busy = (r_state != S_IDLE);
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed bench for mips_muldiv_unit (WIDTH=32): arithmetic corners,
// handshake latency, busy-start drop, mthi/mtlo gating, flush and async reset.
module tb_mips_muldiv_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mips_muldiv_unit_if #(.WIDTH(32)) bus();
  mips_muldiv_unit #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic drive_idle();
    bus.start = 1'b0; bus.op = 2'b00; bus.src_a = '0; bus.src_b = '0;
    bus.flush = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
  endtask

  // Called at a negedge; returns at the negedge on which done is seen.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int edges, output bit busy_ok);
    bus.op = op; bus.src_a = a; bus.src_b = b; bus.start = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.start = 1'b0;
    edges = 0;
    busy_ok = bus.busy;
    while (!bus.done && edges < 100) begin
      @(posedge clk); edges++; @(negedge clk);
      if (!bus.done && !bus.busy) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    #2;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want 00000000", bus.hi); end
    checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want 00000000", bus.lo); end
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", bus.busy); end
  endtask

  task automatic test_mult();
    int e; bit bok;
    run_op(2'b00, 32'hFFFFFFFF, 32'h00000002, e, bok);
    checks++; if (e !== 33) begin errors++; $display("FAIL mult_latency got %0d want 33", e); end
    checks++; if (bok !== 1'b1) begin errors++; $display("FAIL mult_busy_hold got %b want 1", bok); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mult_busy_at_done got %b want 0", bus.busy); end
    checks++; if (bus.hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got %h want ffffffff", bus.hi); end
    checks++; if (bus.lo !== 32'hFFFFFFFE) begin errors++; $display("FAIL mult_lo got %h want fffffffe", bus.lo); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL mult_done_pulse got %b want 0", bus.done); end
    run_op(2'b01, 32'hFFFFFFFF, 32'h00000002, e, bok);
    checks++; if (e !== 33) begin errors++; $display("FAIL multu_latency got %0d want 33", e); end
    checks++; if (bus.hi !== 32'h00000001) begin errors++; $display("FAIL multu_hi got %h want 00000001", bus.hi); end
    checks++; if (bus.lo !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_lo got %h want fffffffe", bus.lo); end
    run_op(2'b00, 32'h7FFFFFFF, 32'h80000000, e, bok);
    checks++; if (bus.hi !== 32'hC0000000) begin errors++; $display("FAIL mult_ext_hi got %h want c0000000", bus.hi); end
    checks++; if (bus.lo !== 32'h80000000) begin errors++; $display("FAIL mult_ext_lo got %h want 80000000", bus.lo); end
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, e, bok);
    checks++; if (bus.hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_max_hi got %h want fffffffe", bus.hi); end
    checks++; if (bus.lo !== 32'h00000001) begin errors++; $display("FAIL multu_max_lo got %h want 00000001", bus.lo); end
  endtask

  task automatic test_div();
    int e; bit bok;
    run_op(2'b10, 32'hFFFFFFF9, 32'h00000002, e, bok);
    checks++; if (e !== 33) begin errors++; $display("FAIL div_latency got %0d want 33", e); end
    checks++; if (bus.lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_neg_lo got %h want fffffffd", bus.lo); end
    checks++; if (bus.hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_neg_hi got %h want ffffffff", bus.hi); end
    run_op(2'b11, 32'h00000007, 32'h00000002, e, bok);
    checks++; if (bus.lo !== 32'h00000003) begin errors++; $display("FAIL divu_lo got %h want 00000003", bus.lo); end
    checks++; if (bus.hi !== 32'h00000001) begin errors++; $display("FAIL divu_hi got %h want 00000001", bus.hi); end
    run_op(2'b10, 32'h00000007, 32'hFFFFFFFE, e, bok);
    checks++; if (bus.lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_negb_lo got %h want fffffffd", bus.lo); end
    checks++; if (bus.hi !== 32'h00000001) begin errors++; $display("FAIL div_negb_hi got %h want 00000001", bus.hi); end
  endtask

  task automatic test_div_special();
    int e; bit bok;
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, e, bok);
    checks++; if (bus.lo !== 32'h80000000) begin errors++; $display("FAIL div_ovf_lo got %h want 80000000", bus.lo); end
    checks++; if (bus.hi !== 32'h00000000) begin errors++; $display("FAIL div_ovf_hi got %h want 00000000", bus.hi); end
    run_op(2'b11, 32'h00000005, 32'h00000000, e, bok);
    checks++; if (e !== 33) begin errors++; $display("FAIL div0_latency got %0d want 33", e); end
    checks++; if (bus.lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL div0_lo got %h want ffffffff", bus.lo); end
    checks++; if (bus.hi !== 32'h00000005) begin errors++; $display("FAIL div0_hi got %h want 00000005", bus.hi); end
    run_op(2'b11, 32'hFFFFFFFF, 32'h00000001, e, bok);
    checks++; if (bus.lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL divu_max_lo got %h want ffffffff", bus.lo); end
    checks++; if (bus.hi !== 32'h00000000) begin errors++; $display("FAIL divu_max_hi got %h want 00000000", bus.hi); end
  endtask

  task automatic test_start_while_busy();
    int e;
    bus.op = 2'b11; bus.src_a = 32'd100; bus.src_b = 32'd7; bus.start = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.start = 1'b0;
    e = 0;
    while (!bus.done && e < 100) begin
      @(posedge clk); e++; @(negedge clk);
      if (e == 5) begin
        bus.start = 1'b1; bus.op = 2'b00; bus.src_a = 32'd50; bus.src_b = 32'd3;
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    checks++; if (e !== 33) begin errors++; $display("FAIL busy_start_latency got %0d want 33", e); end
    checks++; if (bus.lo !== 32'd14) begin errors++; $display("FAIL busy_start_lo got %h want 0000000e", bus.lo); end
    checks++; if (bus.hi !== 32'd2) begin errors++; $display("FAIL busy_start_hi got %h want 00000002", bus.hi); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL busy_start_no_queue got %b want 0", bus.busy); end
  endtask

  task automatic test_back_to_back();
    int e; bit bok;
    run_op(2'b11, 32'd100, 32'd7, e, bok);
    run_op(2'b00, 32'd6, 32'hFFFFFFFF, e, bok);
    checks++; if (e !== 33) begin errors++; $display("FAIL b2b_latency got %0d want 33", e); end
    checks++; if (bus.hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL b2b_hi got %h want ffffffff", bus.hi); end
    checks++; if (bus.lo !== 32'hFFFFFFFA) begin errors++; $display("FAIL b2b_lo got %h want fffffffa", bus.lo); end
  endtask

  task automatic test_flush();
    int e; bit saw_done;
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h0BADF00D;
    @(posedge clk); @(negedge clk);
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    checks++; if (bus.hi !== 32'h0BADF00D) begin errors++; $display("FAIL both_we_hi got %h want 0badf00d", bus.hi); end
    checks++; if (bus.lo !== 32'h0BADF00D) begin errors++; $display("FAIL both_we_lo got %h want 0badf00d", bus.lo); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL mt_done got %b want 0", bus.done); end
    bus.hi_we = 1'b1; bus.wdata = 32'h12345678;
    @(posedge clk); @(negedge clk);
    bus.hi_we = 1'b0; bus.lo_we = 1'b1; bus.wdata = 32'hCAFEF00D;
    @(posedge clk); @(negedge clk);
    bus.lo_we = 1'b0;
    checks++; if (bus.hi !== 32'h12345678) begin errors++; $display("FAIL mthi got %h want 12345678", bus.hi); end
    checks++; if (bus.lo !== 32'hCAFEF00D) begin errors++; $display("FAIL mtlo got %h want cafef00d", bus.lo); end
    bus.op = 2'b00; bus.src_a = 32'd3; bus.src_b = 32'd4; bus.start = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.start = 1'b0;
    e = 0;
    while (e < 10) begin
      @(posedge clk); e++; @(negedge clk);
      bus.hi_we = (e == 3); bus.wdata = 32'hDEADBEEF;
    end
    bus.hi_we = 1'b0;
    bus.flush = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.flush = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b want 0", bus.busy); end
    saw_done = bus.done;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) saw_done = 1'b1;
    end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL flush_no_done got %b want 0", saw_done); end
    checks++; if (bus.hi !== 32'h12345678) begin errors++; $display("FAIL flush_hi got %h want 12345678", bus.hi); end
    checks++; if (bus.lo !== 32'hCAFEF00D) begin errors++; $display("FAIL flush_lo got %h want cafef00d", bus.lo); end
    bus.start = 1'b1; bus.flush = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_start_busy got %b want 0", bus.busy); end
  endtask

  task automatic test_reset_mid();
    int e; bit bok;
    bus.op = 2'b00; bus.src_a = 32'd6; bus.src_b = 32'd6; bus.start = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL rst_mid_hi got %h want 00000000", bus.hi); end
    checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL rst_mid_lo got %h want 00000000", bus.lo); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_mid_done got %b want 0", bus.done); end
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    run_op(2'b00, 32'd6, 32'd7, e, bok);
    checks++; if (e !== 33) begin errors++; $display("FAIL post_rst_latency got %0d want 33", e); end
    checks++; if (bus.lo !== 32'd42) begin errors++; $display("FAIL post_rst_lo got %h want 0000002a", bus.lo); end
    checks++; if (bus.hi !== 32'd0) begin errors++; $display("FAIL post_rst_hi got %h want 00000000", bus.hi); end
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_mult();
    test_div();
    test_div_special();
    test_start_while_busy();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
